layer_argmax_reader: RTL and testbench
======================================

Name: layer_argmax_reader

Overview:
- Reads the flattened signed neuron outputs (zed) of the final layer and returns the index of the largest value as the classified digit.
- Takes a snapshot of zed on a start handshake, then scans one neuron per clock.
- Presents the result through a valid/ready handshake to downstream logic (display, UART reporter).
- Sits directly after the output layer of the network.

Parameters:
- number_neuron, 10, number of neuron outputs to scan (>=1).
- resolution, 8, bit width of each signed neuron output.
- Derived localparam idx_w = max(1, clog2(number_neuron)); not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request to classify the current zed; accepted only when start_ready=1.
- start_ready  output  1  high exactly when the FSM is in IDLE.
- zed  input  resolution*number_neuron  flattened signed outputs; neuron i at bits [(i+1)*resolution-1 -: resolution].
- busy  output  1  high in SCAN and DONE.
- result_valid  output  1  high in DONE.
- result_ready  input  1  downstream accepts the result.
- digit  output  idx_w  index of the maximum element.
- max_value  output  resolution  signed value of the maximum element.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; digit=0, max_value=0, result_valid=0, busy=0, start_ready=1 after the edge. Internal snapshot and scan index are cleared to 0.
- Reset asserted mid-scan or in DONE aborts immediately. No result is produced and no result_valid pulse occurs.
- FSM states: IDLE, SCAN, DONE.
- IDLE, on start=1 at an edge:
  - snapshot <= zed (the whole vector; later changes on zed are ignored).
  - best_val <= element 0, best_idx <= 0, scan_idx <= 1.
  - Next state = SCAN, or DONE directly when number_neuron=1.
- IDLE, start=0: stay in IDLE.
- SCAN, each cycle:
  - Compare snapshot[scan_idx] against best_val as signed (two's complement).
  - Update best only if strictly greater, so ties keep the lowest index.
  - If scan_idx == number_neuron-1, go to DONE; otherwise scan_idx <= scan_idx+1.
- DONE:
  - result_valid=1; digit and max_value show the final best.
  - Outputs stay stable while result_valid=1 and result_ready=0.
  - On result_valid=1 and result_ready=1 at an edge, go to IDLE and drop result_valid.
  - digit and max_value keep their last values in IDLE until the next result replaces them.
- Latency: start accepted at edge k, result_valid high after edge k+number_neuron-1. For N=10: 9 cycles, and a new start is accepted no sooner than edge k+10.
- start while not IDLE: ignored, with no effect on the snapshot or the scan.
- result_ready already high when DONE is entered: handshake completes at the next edge, giving a one-cycle valid pulse.
- Arithmetic: only signed comparisons, no arithmetic widening. max_value is a copied bit field.

Test Plan:
- Reset, then idle: after reset=0 for 2 edges and release → start_ready=1, busy=0, result_valid=0, digit=0, max_value=0.
- Basic argmax, N=10, res=8: zed elements {3,-5,12,7,0,-128,12,9,1,2}, start one cycle with result_ready=1 → result_valid after 9 edges; digit=2 (tie with index 6 keeps lowest); max_value=12.
- Signed and negative case: all elements -100 except element 9 = -1 → digit=9, max_value=-1 (0xFF). All -128 → digit=0, max_value=-128.
- Snapshot and backpressure:
  - Change zed to make element 4 = 127 one cycle after start → digit unaffected.
  - Hold result_ready=0 for 5 cycles in DONE → outputs stable and result_valid held.
  - start pulses during SCAN and DONE are ignored.
  - Release result_ready → IDLE next edge.
- Reset mid-operation: reset=0 at scan_idx=4 → next edge state IDLE, result_valid never asserted. A fresh start then gives a correct result.
- N=1 configuration: zed=8'sd-7, start → result_valid after 1 edge; digit=0, max_value=-7.

Source files
------------

// File: rtl/layer_argmax_reader.sv
// layer_argmax_reader: snapshots zed on start, scans one neuron per clock, returns the argmax over a valid/ready handshake
module layer_argmax_reader #(
    parameter int number_neuron = 10,
    parameter int resolution = 8,
    localparam int idx_w = number_neuron > 1 ? $clog2(number_neuron) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                start_ready,
    input  logic [resolution*number_neuron-1:0] zed,
    output logic                                busy,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [idx_w-1:0]                    digit,
    output logic [resolution-1:0]               max_value
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [idx_w-1:0] last_idx = idx_w'(number_neuron - 1);
    state_t state_q, state_d;
    logic [resolution*number_neuron-1:0] snap_q, snap_d;
    logic signed [resolution-1:0] best_val_q, best_val_d, cur_val;
    logic [idx_w-1:0] best_idx_q, best_idx_d, scan_idx_q, scan_idx_d;
    always_comb begin
        state_d = state_q;
        snap_d = snap_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        scan_idx_d = scan_idx_q;
        cur_val = snap_q[int'(scan_idx_q)*resolution +: resolution];
        case (state_q)
            IDLE: if (start) begin
                snap_d = zed;
                best_val_d = zed[resolution-1:0];
                best_idx_d = '0;
                scan_idx_d = idx_w'(1);
                state_d = number_neuron == 1 ? DONE : SCAN;
            end
            SCAN: begin
                // strict compare keeps the lowest index on ties
                if (cur_val > best_val_q) begin
                    best_val_d = cur_val;
                    best_idx_d = scan_idx_q;
                end
                if (scan_idx_q == last_idx) state_d = DONE;
                else scan_idx_d = scan_idx_q + idx_w'(1);
            end
            DONE: if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            snap_q <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            scan_idx_q <= '0;
        end else begin
            state_q <= state_d;
            snap_q <= snap_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            scan_idx_q <= scan_idx_d;
        end
    end
    assign start_ready = state_q == IDLE;
    assign busy = state_q != IDLE;
    assign result_valid = state_q == DONE;
    assign digit = best_idx_q;
    assign max_value = best_val_q;
endmodule

// File: tb/tb_layer_argmax_reader.sv
// tb_layer_argmax_reader: directed and randomized checks of layer_argmax_reader against an array-based argmax model
module tb_layer_argmax_reader;
    logic clk = 0, reset = 0, start = 0, result_ready = 0;
    logic [79:0] zed = '0;
    logic start_ready, busy, result_valid;
    logic [3:0] digit;
    logic signed [7:0] max_value;
    logic start1 = 0, ready1 = 0;
    logic [7:0] zed1 = '0;
    logic start_ready1, busy1, valid1;
    logic [0:0] digit1;
    logic signed [7:0] max1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    layer_argmax_reader #(.number_neuron(10), .resolution(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ready(start_ready), .zed(zed),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .digit(digit), .max_value(max_value));

    layer_argmax_reader #(.number_neuron(1), .resolution(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .start_ready(start_ready1), .zed(zed1),
        .busy(busy1), .result_valid(valid1), .result_ready(ready1),
        .digit(digit1), .max_value(max1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic void ref_model(input int v[10], output int idx, output int mx);
        idx = 0;
        mx = v[0];
        for (int i = 1; i < 10; i++) if (v[i] > mx) begin
            mx = v[i];
            idx = i;
        end
    endfunction

    task automatic set_zed(input int v[10]);
        for (int i = 0; i < 10; i++) zed[i*8 +: 8] = 8'(v[i]);
    endtask

    task automatic run(input int v[10], input string tag);
        int idx, mx, cyc;
        ref_model(v, idx, mx);
        set_zed(v);
        result_ready = 1;
        start = 1;
        tick();
        start = 0;
        cyc = 0;
        while (!result_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 9);
        chk({tag, "_digit"}, digit, idx);
        chk({tag, "_max"}, max_value, mx);
        tick();
        chk({tag, "_idle"}, {start_ready, busy, result_valid}, 3'b100);
    endtask

    initial begin
        int v[10];
        int idx, mx, cyc;
        bit seen_valid;
        tick();
        tick();
        reset = 1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_digit", digit, 0);
        chk("rst_max", max_value, 0);

        v = '{3, -5, 12, 7, 0, -128, 12, 9, 1, 2};
        run(v, "basic");
        for (int i = 0; i < 10; i++) v[i] = -100;
        v[9] = -1;
        run(v, "neg_last");
        for (int i = 0; i < 10; i++) v[i] = -128;
        run(v, "all_min");

        for (int i = 0; i < 10; i++) v[i] = int'($urandom_range(0, 200)) - 100;
        ref_model(v, idx, mx);
        set_zed(v);
        result_ready = 0;
        start = 1;
        tick();
        zed[4*8 +: 8] = 8'd127;
        tick();
        start = 0;
        cyc = 1;
        while (!result_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_latency", cyc, 9);
        chk("bp_digit", digit, idx);
        chk("bp_max", max_value, mx);
        for (int k = 0; k < 5; k++) begin
            start = k[0];
            tick();
            chk("bp_hold_valid", result_valid, 1);
            chk("bp_hold_digit", digit, idx);
            chk("bp_hold_max", max_value, mx);
        end
        start = 0;
        result_ready = 1;
        tick();
        chk("bp_release", {start_ready, busy, result_valid}, 3'b100);
        chk("bp_keep_digit", digit, idx);
        chk("bp_keep_max", max_value, mx);

        for (int i = 0; i < 10; i++) v[i] = int'(byte'($urandom));
        set_zed(v);
        result_ready = 1;
        seen_valid = 0;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 3; k++) begin
            seen_valid |= result_valid;
            tick();
        end
        seen_valid |= result_valid;
        reset = 0;
        tick();
        chk("mid_rst_state", {start_ready, busy, result_valid}, 3'b100);
        reset = 1;
        for (int k = 0; k < 12; k++) begin
            seen_valid |= result_valid;
            tick();
        end
        chk("mid_rst_no_valid", seen_valid, 0);
        for (int i = 0; i < 10; i++) v[i] = int'(byte'($urandom));
        run(v, "after_rst");

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 10; i++)
                v[i] = n[0] ? int'($urandom_range(0, 6)) - 3 : int'(byte'($urandom));
            run(v, "rand");
        end

        zed1 = 8'hF9;
        ready1 = 1;
        start1 = 1;
        tick();
        start1 = 0;
        chk("n1_valid", valid1, 1);
        chk("n1_digit", digit1, 0);
        chk("n1_max", max1, -7);
        tick();
        chk("n1_idle", {start_ready1, busy1, valid1}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
